// File: rtl/sume_ctrl_if.sv
// Handshake/bus bundle for sume_ctrl: operand nibble entry, result and status.
// The ovf signal exists only when SUME_CTRL_OVF_EN is defined.
interface sume_ctrl_if #(
  parameter int unsigned DIGITS = 3
);
  localparam int unsigned W = 4 * DIGITS;

  logic         start;
  logic         abort;
  logic [3:0]   sample;
  logic         sample_valid;
  logic         sample_ready;
  logic         sum_ack;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [W-1:0] sum;
  logic         sum_valid;
  logic         busy;
`ifdef SUME_CTRL_OVF_EN
  logic         ovf;
`endif

  modport slave (
`ifdef SUME_CTRL_OVF_EN
    output ovf,
`endif
    input  start, abort, sample, sample_valid, sum_ack,
    output sample_ready, op_a, op_b, sum, sum_valid, busy
  );

  modport master (
`ifdef SUME_CTRL_OVF_EN
    input  ovf,
`endif
    output start, abort, sample, sample_valid, sum_ack,
    input  sample_ready, op_a, op_b, sum, sum_valid, busy
  );
endinterface

// File: rtl/sume_ctrl.sv
// Nibble-serial two-operand adder controller: loads A then B MSB-first, adds, holds until ack.
// Define SUME_CTRL_OVF_EN to add the registered carry-out flag (bus.ovf).
module sume_ctrl #(
  parameter int unsigned DIGITS = 3
) (
  input  logic        clk,
  input  logic        reset,
  sume_ctrl_if.slave  bus
);
  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, ADD, HOLD} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  op_a_q, op_a_d;
  logic [W-1:0]  op_b_q, op_b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          last_dig;
  logic          xfer;
`ifdef SUME_CTRL_OVF_EN
  logic          ovf_q, ovf_d;
  logic [W:0]    add_full;
`endif

  assign bus.sample_ready = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign bus.sum_valid    = (state_q == HOLD);
  assign bus.busy         = (state_q != IDLE);
  assign bus.op_a         = op_a_q;
  assign bus.op_b         = op_b_q;
  assign bus.sum          = sum_q;
`ifdef SUME_CTRL_OVF_EN
  assign bus.ovf          = ovf_q;
  assign add_full         = {1'b0, op_a_q} + {1'b0, op_b_q};
`endif

  assign xfer     = bus.sample_valid && bus.sample_ready;
  assign last_dig = (cnt_q == CW'(DIGITS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
`ifdef SUME_CTRL_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      sum_q   <= sum_d;
`ifdef SUME_CTRL_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    sum_d   = sum_q;
`ifdef SUME_CTRL_OVF_EN
    ovf_d   = ovf_q;
`endif
    // Abort outranks start, transfers and ack; operands and sum are kept for inspection.
    if (bus.abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_d = LOAD_A;
            cnt_d   = '0;
            op_a_d  = '0;
            op_b_d  = '0;
            sum_d   = '0;
`ifdef SUME_CTRL_OVF_EN
            ovf_d   = 1'b0;
`endif
          end
        end
        LOAD_A: begin
          if (xfer) begin
            op_a_d = W'({op_a_q, bus.sample});
            cnt_d  = cnt_q + 1'b1;
            if (last_dig) begin
              state_d = LOAD_B;
              cnt_d   = '0;
            end
          end
        end
        LOAD_B: begin
          if (xfer) begin
            op_b_d = W'({op_b_q, bus.sample});
            cnt_d  = cnt_q + 1'b1;
            if (last_dig) begin
              state_d = ADD;
              cnt_d   = '0;
            end
          end
        end
        ADD: begin
`ifdef SUME_CTRL_OVF_EN
          sum_d = add_full[W-1:0];
          ovf_d = add_full[W];
`else
          sum_d = op_a_q + op_b_q;
`endif
          state_d = HOLD;
        end
        HOLD: begin
          if (bus.sum_ack) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sume_ctrl.sv
// Scoreboard bench for sume_ctrl: expected sums queued at stimulus time, compared on sum_valid.
// Honours SUME_CTRL_OVF_EN for the carry-out checks.
module tb_sume_ctrl;
  localparam int unsigned DIGITS = 3;
  localparam int unsigned W      = 4 * DIGITS;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] s;
    logic         c;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];

  sume_ctrl_if #(.DIGITS(DIGITS)) bus ();

  sume_ctrl #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_nib(input logic [3:0] n, input int unsigned maxgap);
    int unsigned gap;
    gap = (maxgap == 0) ? 0 : $urandom_range(0, maxgap);
    for (int unsigned g = 0; g < gap; g++) begin
      bus.sample       = 4'($urandom);
      bus.sample_valid = 1'b0;
      tick();
    end
    bus.sample       = n;
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
  endtask

  task automatic send_op(input logic [W-1:0] v, input int unsigned maxgap);
    for (int d = DIGITS - 1; d >= 0; d--) send_nib(v[4*d +: 4], maxgap);
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Full sequence: queue expectation, load both operands, wait for result, hold, ack.
  task automatic run_seq(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int unsigned maxgap, input int unsigned ack_delay,
                         input bit hold_start, input bit pulse);
    exp_t        e;
    logic [W:0]  full;
    int unsigned lat;
    full = {1'b0, a} + {1'b0, b};
    e.a  = a;
    e.b  = b;
    e.s  = full[W-1:0];
    e.c  = full[W];
    sb.push_back(e);

    if (pulse) begin
      bus.sample       = 4'hF;
      bus.sample_valid = 1'b1;
      tick();
      bus.sample_valid = 1'b0;
      check_eq("idle_pulse_busy", 32'(bus.busy), 32'd0);
    end
    do_start();
    check_eq("start_busy", 32'(bus.busy), 32'd1);
    check_eq("start_ready", 32'(bus.sample_ready), 32'd1);
    check_eq("start_clr_sum", 32'(bus.sum), 32'd0);
    check_eq("start_clr_opb", 32'(bus.op_b), 32'd0);
    send_op(a, maxgap);
    check_eq("op_a_loaded", 32'(bus.op_a), 32'(a));
    send_op(b, maxgap);
    check_eq("valid_in_add", 32'(bus.sum_valid), 32'd0);
    check_eq("ready_in_add", 32'(bus.sample_ready), 32'd0);
    lat = 0;
    while (!bus.sum_valid && lat < 20) begin
      tick();
      lat++;
    end
    check_eq("sum_latency", 32'(lat), 32'd1);

    if (sb.size() == 0) begin
      check_eq("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check_eq("sum", 32'(bus.sum), 32'(e.s));
      check_eq("op_a", 32'(bus.op_a), 32'(e.a));
      check_eq("op_b", 32'(bus.op_b), 32'(e.b));
`ifdef SUME_CTRL_OVF_EN
      check_eq("ovf", 32'(bus.ovf), 32'(e.c));
`endif
    end

    if (pulse) begin
      bus.sample       = 4'hE;
      bus.sample_valid = 1'b1;
      tick();
      bus.sample_valid = 1'b0;
      check_eq("hold_pulse_opb", 32'(bus.op_b), 32'(e.b));
    end
    bus.start = hold_start;
    for (int unsigned i = 0; i < ack_delay; i++) begin
      tick();
      check_eq("hold_sum", 32'(bus.sum), 32'(e.s));
      check_eq("hold_valid", 32'(bus.sum_valid), 32'd1);
    end
    bus.sum_ack = 1'b1;
    tick();
    bus.sum_ack = 1'b0;
    bus.start   = 1'b0;
    check_eq("ack_valid", 32'(bus.sum_valid), 32'd0);
    check_eq("ack_busy", 32'(bus.busy), 32'd0);
    check_eq("ack_sum_kept", 32'(bus.sum), 32'(e.s));
    if (hold_start) begin
      tick();
      check_eq("ack_start_ignored", 32'(bus.busy), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks         = 0;
    n_fail           = 0;
    reset            = 1'b1;
    bus.start        = 1'b0;
    bus.abort        = 1'b0;
    bus.sample       = 4'h0;
    bus.sample_valid = 1'b0;
    bus.sum_ack      = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_ready", 32'(bus.sample_ready), 32'd0);
    check_eq("rst_valid", 32'(bus.sum_valid), 32'd0);
    check_eq("rst_sum", 32'(bus.sum), 32'd0);
    check_eq("rst_op_a", 32'(bus.op_a), 32'd0);
    check_eq("rst_op_b", 32'(bus.op_b), 32'd0);

    run_seq(12'h123, 12'h456, 0, 0, 1'b0, 1'b0);
    run_seq(12'hFFF, 12'h001, 0, 1, 1'b0, 1'b0);
    run_seq(12'h7FF, 12'h001, 0, 0, 1'b0, 1'b0);
    run_seq(12'h123, 12'h456, 5, 2, 1'b0, 1'b1);

    // Abort after the second B nibble.
    do_start();
    send_op(12'h321, 0);
    send_nib(4'h4, 0);
    send_nib(4'h5, 0);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_eq("abort_busy", 32'(bus.busy), 32'd0);
    check_eq("abort_valid", 32'(bus.sum_valid), 32'd0);
    check_eq("abort_ready", 32'(bus.sample_ready), 32'd0);
    check_eq("abort_op_a_kept", 32'(bus.op_a), 32'h321);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check_eq("abort_start_idle", 32'(bus.busy), 32'd0);
    run_seq(12'hABC, 12'h111, 0, 0, 1'b0, 1'b0);

    // Reset in LOAD_A after one nibble.
    do_start();
    send_nib(4'hA, 0);
    check_eq("pre_rst_op_a", 32'(bus.op_a), 32'h00A);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("midrst_busy", 32'(bus.busy), 32'd0);
    check_eq("midrst_ready", 32'(bus.sample_ready), 32'd0);
    check_eq("midrst_op_a", 32'(bus.op_a), 32'd0);
    check_eq("midrst_sum", 32'(bus.sum), 32'd0);
    check_eq("midrst_valid", 32'(bus.sum_valid), 32'd0);
    run_seq(12'h0F0, 12'h00F, 0, 0, 1'b0, 1'b0);

    // Delayed ack with start held through HOLD.
    run_seq(12'h999, 12'h888, 3, 10, 1'b1, 1'b0);
    check_eq("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
